// File: rtl/adc_multich_avg.sv
// adc_multich_avg: scans enabled ADC channels, averages 2^LOG2_N conversions
// per channel and emits one tagged, optionally rounded result per channel.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse, begins a scan when idle and ch_mask != 0
//   abort             level, returns to idle on the next edge
//   continuous        rescan from channel 0 after each completed scan
//   ch_mask           channel enables, latched when start is accepted
//   conv_req          one-cycle conversion request to the serial ADC driver
//   conv_addr         {channel, CFG_NIB}, held from conv_req to conv_done
//   conv_done         one-cycle pulse, conv_data valid
//   conv_data         conversion result (pipelined one request behind)
//   ave_data, ave_ch  channel average and its channel tag
//   ave_valid         one-cycle strobe for ave_data/ave_ch
//   scan_done         one-cycle strobe with the last channel's ave_valid
//   busy              high outside IDLE
//   timeout_err       sticky, set when conv_done never arrives
`timescale 1ns/1ps

module adc_multich_avg #(
    parameter int         DATA_W      = 12,
    parameter int         LOG2_N      = 5,
    parameter int         NUM_CH      = 4,
    parameter int         DISCARD     = 1,
    parameter logic [3:0] CFG_NIB     = 4'b1000,
    parameter bit         ROUND       = 1'b1,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              conv_req,
    output logic [7:0]        conv_addr,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_data,
    output logic [DATA_W-1:0] ave_data,
    output logic [3:0]        ave_ch,
    output logic              ave_valid,
    output logic              scan_done,
    output logic              busy,
    output logic              timeout_err
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [ACC_W-1:0]  HALF =
        ROUND ? (ACC_W'(1) << (LOG2_N - 1)) : '0;
    localparam logic [LOG2_N-1:0] CNT_LAST  = '1;
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]        DISC_INIT = 2'(DISCARD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [3:0]          ptr_q, ptr_d;
    logic [3:0]          ch_q, ch_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_N-1:0]   cnt_q, cnt_d;
    logic [1:0]          disc_q, disc_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [7:0]          addr_q, addr_d;
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic [3:0]          avch_q, avch_d;
    logic                avv_q, avv_d;
    logic                sdone_q, sdone_d;
    logic                terr_q, terr_d;

    logic [3:0]          sel_ch;
    logic                more_above;

    // Lowest enabled channel at or above the scan pointer.
    always_comb begin
        sel_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (4'(i) >= ptr_q)) begin
                sel_ch = 4'(i);
            end
        end
    end

    // Any enabled channel left above the one just averaged.
    always_comb begin
        more_above = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask_q[i] && (4'(i) > ch_q)) begin
                more_above = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        disc_d  = disc_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        avg_d   = avg_q;
        avch_d  = avch_q;
        avv_d   = 1'b0;
        sdone_d = 1'b0;
        terr_d  = terr_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && (|ch_mask)) begin
                        mask_d  = ch_mask;
                        terr_d  = 1'b0;
                        ptr_d   = '0;
                        state_d = S_SEL;
                    end
                end
                S_SEL: begin
                    ch_d    = sel_ch;
                    addr_d  = {sel_ch, CFG_NIB};
                    acc_d   = '0;
                    cnt_d   = '0;
                    disc_d  = DISC_INIT;
                    state_d = S_REQ;
                end
                S_REQ: begin
                    // Counts cycles since conv_req, so WAIT starts at 1.
                    tmo_d   = TMO_W'(1);
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (conv_done) begin
                        if (disc_q != 2'd0) begin
                            disc_d  = disc_q - 2'd1;
                            state_d = S_REQ;
                        end else begin
                            acc_d   = acc_q + ACC_W'(conv_data);
                            cnt_d   = cnt_q + 1'b1;
                            state_d = (cnt_q == CNT_LAST) ? S_OUT : S_REQ;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        terr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_OUT: begin
                    // acc + HALF cannot overflow ACC_W and the quotient
                    // always fits DATA_W.
                    avg_d  = DATA_W'((acc_q + HALF) >> LOG2_N);
                    avch_d = ch_q;
                    avv_d  = 1'b1;
                    if (more_above) begin
                        ptr_d   = ch_q + 4'd1;
                        state_d = S_SEL;
                    end else begin
                        sdone_d = 1'b1;
                        if (continuous) begin
                            ptr_d   = '0;
                            state_d = S_SEL;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            ptr_q   <= '0;
            ch_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            disc_q  <= '0;
            tmo_q   <= '0;
            addr_q  <= {4'd0, CFG_NIB};
            avg_q   <= '0;
            avch_q  <= '0;
            avv_q   <= 1'b0;
            sdone_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            disc_q  <= disc_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            avg_q   <= avg_d;
            avch_q  <= avch_d;
            avv_q   <= avv_d;
            sdone_q <= sdone_d;
            terr_q  <= terr_d;
        end
    end

    assign conv_req    = (state_q == S_REQ);
    assign busy        = (state_q != S_IDLE);
    assign conv_addr   = addr_q;
    assign ave_data    = avg_q;
    assign ave_ch      = avch_q;
    assign ave_valid   = avv_q;
    assign scan_done   = sdone_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_adc_multich_avg.sv
// tb_adc_multich_avg: randomized bench with a cycle-level reference model,
// a pipelined ADC driver emulator and directed literal checks.
`timescale 1ns/1ps

module tb_adc_multich_avg;

    localparam int         DW   = 12;
    localparam int         L2N  = 2;
    localparam int         N    = 4;
    localparam int         NCH  = 4;
    localparam int         DISC = 1;
    localparam int         TMO  = 16;
    localparam logic [3:0] NIB  = 4'b1000;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, continuous;
    logic [3:0]    ch_mask;
    logic          conv_done;
    logic [DW-1:0] conv_data;
    logic          withhold;

    logic          conv_req, ave_valid, scan_done, busy, timeout_err;
    logic [7:0]    conv_addr;
    logic [DW-1:0] ave_data;
    logic [3:0]    ave_ch;

    logic          t_conv_req, t_ave_valid, t_scan_done, t_busy, t_terr;
    logic [7:0]    t_conv_addr;
    logic [DW-1:0] t_ave_data;
    logic [3:0]    t_ave_ch;

    adc_multich_avg #(
        .DATA_W(DW), .LOG2_N(L2N), .NUM_CH(NCH), .DISCARD(DISC),
        .CFG_NIB(NIB), .ROUND(1'b1), .TIMEOUT_CYC(TMO)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .continuous(continuous), .ch_mask(ch_mask),
        .conv_req(conv_req), .conv_addr(conv_addr),
        .conv_done(conv_done), .conv_data(conv_data),
        .ave_data(ave_data), .ave_ch(ave_ch), .ave_valid(ave_valid),
        .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err)
    );

    adc_multich_avg #(
        .DATA_W(DW), .LOG2_N(L2N), .NUM_CH(NCH), .DISCARD(DISC),
        .CFG_NIB(NIB), .ROUND(1'b0), .TIMEOUT_CYC(TMO)
    ) u_trn (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .continuous(continuous), .ch_mask(ch_mask),
        .conv_req(t_conv_req), .conv_addr(t_conv_addr),
        .conv_done(conv_done), .conv_data(conv_data),
        .ave_data(t_ave_data), .ave_ch(t_ave_ch), .ave_valid(t_ave_valid),
        .scan_done(t_scan_done), .busy(t_busy), .timeout_err(t_terr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    // ADC driver emulator: answers each request after 1..4 cycles.
    int script[$];
    initial begin
        int lat;
        conv_done = 1'b0;
        conv_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && conv_req && !withhold) begin
                lat = $urandom_range(1, 4);
                repeat (lat) @(posedge clk);
                #1;
                conv_done = 1'b1;
                if (script.size() > 0) conv_data = DW'(script.pop_front());
                else conv_data = DW'($urandom_range(0, 4095));
                @(posedge clk);
                #1;
                conv_done = 1'b0;
            end
        end
    end

    // Event monitor feeding the directed literal checks.
    int n_req = 0, n_req18 = 0, n_val = 0, n_sd = 0;
    int last_done_cyc = 0, last_val_cyc = 0;
    int log_ch[$], log_r[$], log_t[$];
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (conv_req) n_req++;
            if (conv_req && conv_addr == 8'h18) n_req18++;
            if (conv_done) last_done_cyc = cyc;
            if (scan_done) n_sd++;
            if (ave_valid) begin
                n_val++;
                last_val_cyc = cyc;
                log_ch.push_back(int'(ave_ch));
                log_r.push_back(int'(ave_data));
                log_t.push_back(int'(t_ave_data));
            end
        end
    end

    // Reference model: each channel takes N+DISC conversions, the first
    // DISC are dropped, the rest are averaged. Expectations are for the
    // next cycle; the compare runs first each negedge.
    typedef enum int {PH_NONE, PH_SELECT, PH_REQUEST, PH_WAITING, PH_EMIT} ph_t;
    ph_t        ph;
    logic       m_busy, m_req, m_valid, m_sd, m_err;
    logic [7:0] m_addr;
    int         m_avr, m_avt, m_ch;
    int         m_chs[$], m_smp[$];
    int         m_idx, m_seg, m_wt, m_sum;

    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            ph = PH_NONE; m_busy = 0; m_req = 0; m_valid = 0; m_sd = 0;
            m_err = 0; m_addr = {4'd0, NIB}; m_avr = 0; m_avt = 0; m_ch = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("conv_req", conv_req, m_req);
            chk("conv_addr", conv_addr, m_addr);
            chk("ave_valid", ave_valid, m_valid);
            chk("scan_done", scan_done, m_sd);
            chk("ave_ch", ave_ch, m_ch);
            chk("ave_data_round", ave_data, m_avr);
            chk("ave_data_trunc", t_ave_data, m_avt);
            chk("trunc_valid", t_ave_valid, m_valid);
            chk("timeout_err", timeout_err, m_err);
            m_valid = 0;
            m_sd    = 0;
            if (abort) begin
                ph = PH_NONE; m_busy = 0;
            end else if (!m_busy) begin
                if (start && ch_mask != 0) begin
                    m_chs.delete();
                    for (int i = 0; i < NCH; i++) if (ch_mask[i]) m_chs.push_back(i);
                    m_idx = 0; m_err = 0; m_busy = 1; ph = PH_SELECT;
                end
            end else begin
                case (ph)
                    PH_SELECT: begin
                        m_addr = {4'(m_chs[m_idx]), NIB};
                        m_seg = 0; m_smp.delete(); ph = PH_REQUEST;
                    end
                    PH_REQUEST: begin
                        m_wt = 0; ph = PH_WAITING;
                    end
                    PH_WAITING: begin
                        m_wt++;
                        if (conv_done) begin
                            m_seg++;
                            if (m_seg > DISC) m_smp.push_back(int'(conv_data));
                            ph = (m_seg == N + DISC) ? PH_EMIT : PH_REQUEST;
                        end else if (m_wt == TMO - 1) begin
                            m_err = 1; m_busy = 0; ph = PH_NONE;
                        end
                    end
                    PH_EMIT: begin
                        m_sum = 0;
                        foreach (m_smp[i]) m_sum += m_smp[i];
                        m_avr = (m_sum + N / 2) / N;
                        m_avt = m_sum / N;
                        m_ch = m_chs[m_idx];
                        m_valid = 1;
                        if (m_idx + 1 < m_chs.size()) begin
                            m_idx++; ph = PH_SELECT;
                        end else begin
                            m_sd = 1;
                            if (continuous) begin
                                m_idx = 0; ph = PH_SELECT;
                            end else begin
                                m_busy = 0; ph = PH_NONE;
                            end
                        end
                    end
                    default: ph = PH_NONE;
                endcase
            end
            m_req = (ph == PH_REQUEST);
        end
    end

    task automatic pulse_start(input logic [3:0] m);
        @(posedge clk); #1;
        ch_mask = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ch_mask = 4'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_idle", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_req, b_val, b_sd, b_18, k, tc, te;
        rst_n = 0; start = 0; abort = 0; continuous = 0;
        ch_mask = '0; withhold = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_conv_req", conv_req, 0);
        chk("rst_conv_addr", conv_addr, 8'h08);
        chk("rst_ave_valid", ave_valid, 0);
        chk("rst_ave_data", ave_data, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1;
        repeat (2) @(posedge clk); #1;

        pulse_start(4'b0000);
        repeat (2) @(posedge clk); #1;
        chk("mask0_ignored", busy, 0);

        // Single channel with a discarded stale result.
        script = '{999, 100, 101, 102, 103};
        b_req = n_req; b_val = n_val; b_sd = n_sd;
        log_ch.delete(); log_r.delete(); log_t.delete();
        pulse_start(4'b0100);
        wait_idle(200);
        chk("s1_req_count", n_req - b_req, 5);
        chk("s1_valid_count", n_val - b_val, 1);
        chk("s1_scan_done", n_sd - b_sd, 1);
        chk("s1_ch", qget(log_ch, 0), 2);
        chk("s1_round", qget(log_r, 0), 102);
        chk("s1_trunc", qget(log_t, 0), 101);
        chk("s1_latency", last_val_cyc - last_done_cyc, 2);
        chk("s1_conv_addr", conv_addr, 8'h28);

        // Multi-channel scan, stale first result per channel.
        script = '{7, 10, 10, 10, 10, 10, 4095, 4095, 4095, 4095,
                   4095, 0, 0, 0, 0};
        b_sd = n_sd;
        log_ch.delete(); log_r.delete(); log_t.delete();
        pulse_start(4'b1011);
        wait_idle(300);
        chk("s2_count", log_ch.size(), 3);
        chk("s2_ch0", qget(log_ch, 0), 0);
        chk("s2_ch1", qget(log_ch, 1), 1);
        chk("s2_ch3", qget(log_ch, 2), 3);
        chk("s2_v0", qget(log_r, 0), 10);
        chk("s2_v1", qget(log_r, 1), 4095);
        chk("s2_v3", qget(log_r, 2), 0);
        chk("s2_scan_done", n_sd - b_sd, 1);

        // Rounding vs truncation on 1,1,1,2.
        script = '{7, 1, 1, 1, 2};
        log_ch.delete(); log_r.delete(); log_t.delete();
        pulse_start(4'b0001);
        wait_idle(200);
        chk("s3_round", qget(log_r, 0), 1);
        chk("s3_trunc", qget(log_t, 0), 1);

        // Continuous mode; starts during busy must be ignored.
        b_sd = n_sd;
        continuous = 1;
        pulse_start(4'b0001);
        repeat (3) @(posedge clk);
        pulse_start(4'b1111);
        k = 0;
        while (n_sd - b_sd < 2 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("s4_two_scans", n_sd - b_sd, 2);
        pulse_start(4'b0110);
        continuous = 0;
        wait_idle(300);
        chk("s4_scan_count", n_sd - b_sd, 3);

        // Timeout with conv_done withheld.
        withhold = 1;
        b_val = n_val;
        pulse_start(4'b0010);
        k = 0;
        while (!conv_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("s5_req_seen", conv_req, 1);
        tc = cyc;
        k = 0;
        while (!timeout_err && k < 40) begin
            @(negedge clk);
            k++;
        end
        te = cyc;
        chk("s5_timeout_cycle", te - tc, 16);
        chk("s5_busy", busy, 0);
        chk("s5_no_valid", n_val - b_val, 0);
        withhold = 0;
        repeat (2) @(posedge clk);
        pulse_start(4'b0001);
        chk("s5_err_cleared", timeout_err, 0);
        wait_idle(200);

        // Abort during the 2nd sample of ch1, late conv_done follows.
        b_val = n_val; b_sd = n_sd; b_18 = n_req18;
        pulse_start(4'b0011);
        k = 0;
        while (n_req18 - b_18 < 3 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("s6_reached_ch1", n_req18 - b_18, 3);
        @(posedge clk); #1;
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        chk("s6_idle_next", busy, 0);
        repeat (10) @(posedge clk); #1;
        chk("s6_valid_count", n_val - b_val, 1);
        chk("s6_no_scan_done", n_sd - b_sd, 0);
        chk("s6_still_idle", busy, 0);

        // Random masks and data.
        for (int r = 0; r < 8; r++) begin
            pulse_start(4'($urandom_range(1, 15)));
            wait_idle(400);
        end

        // Asynchronous reset mid-scan.
        pulse_start(4'b1111);
        repeat (12) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("rst2_busy", busy, 0);
        chk("rst2_conv_req", conv_req, 0);
        chk("rst2_conv_addr", conv_addr, 8'h08);
        chk("rst2_ave_data", ave_data, 0);
        chk("rst2_ave_ch", ave_ch, 0);
        chk("rst2_ave_valid", ave_valid, 0);
        chk("rst2_scan_done", scan_done, 0);
        chk("rst2_timeout_err", timeout_err, 0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (10) @(posedge clk);
        pulse_start(4'($urandom_range(1, 15)));
        wait_idle(400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_multich_avg.md
Name: adc_multich_avg

Overview:
- Parametrised multi-channel oversampling controller that sits between the system-state logic and the existing serial ADC driver.
- Scans an enabled set of ADC channels and requests 2^LOG2_N conversions per channel, discarding pipeline-stale results.
- Emits one rounded average per channel with channel tag and valid strobe, in one-shot or continuous mode.
- Supersedes single-channel, fixed-count averaging; adds a conversion timeout with a sticky error flag.

Parameters:
- DATA_W, 12, ADC result width.
- LOG2_N, 5, log2 of samples averaged per channel (N = 2^LOG2_N, 1..8).
- NUM_CH, 4, number of scannable channels (1..16); channel index is 4 bits.
- DISCARD, 1, conversions discarded after each channel change (0..3).
- CFG_NIB, 4'b1000, low nibble of conv_addr (driver format/length config).
- ROUND, 1, 1 = round-half-up, 0 = truncate.
- TIMEOUT_CYC, 4096, max cycles from conv_req to conv_done.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a scan when idle
- abort  in  1  level, terminates activity
- continuous  in  1  1 = rescan after each completed scan
- ch_mask  in  NUM_CH  channel enable, latched at accepted start
- conv_req  out  1  one-cycle conversion request to driver
- conv_addr  out  8  {channel[3:0], CFG_NIB}, stable from conv_req until conv_done
- conv_done  in  1  one-cycle pulse, conv_data valid
- conv_data  in  DATA_W  conversion result (belongs to the previous conv_addr when DISCARD>0)
- ave_data  out  DATA_W  channel average
- ave_ch  out  4  channel of ave_data
- ave_valid  out  1  one-cycle strobe
- scan_done  out  1  one-cycle strobe, end of scan over all enabled channels
- busy  out  1  high outside IDLE
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Interface: single clock clk; reset rst_n asynchronous, active-low.
- Reset: all outputs 0, except conv_addr = {4'd0, CFG_NIB}; FSM to IDLE; accumulator, counters and latched mask cleared.
- Start acceptance: accepted only in IDLE with abort=0 and ch_mask != 0. It latches ch_mask, clears timeout_err, and enters SEL. Start is ignored while busy, and start with ch_mask == 0 is ignored (busy stays 0).
- SEL: pick the lowest enabled channel >= current pointer. Set conv_addr, clear acc and sample_cnt, and load discard_cnt = DISCARD. Go to REQ.
- REQ: assert conv_req for 1 cycle, load the timeout counter, then go to WAIT.
- WAIT, conv_done=1 with discard_cnt > 0: decrement discard_cnt, go to REQ.
- WAIT, conv_done=1 with discard_cnt = 0: acc += conv_data (acc width DATA_W+LOG2_N, never overflows), increment sample_cnt. Go to OUT if sample_cnt reaches N-1 before the increment, otherwise REQ.
- conv_done outside WAIT is ignored.
- Timeout: if the counter reaches TIMEOUT_CYC in WAIT, set timeout_err and go to IDLE. Neither ave_valid nor scan_done is asserted.
- OUT: ave_data = (acc + (ROUND ? 2^(LOG2_N-1) : 0)) >> LOG2_N. The result fits DATA_W with no saturation needed. Set ave_ch and pulse ave_valid for one cycle. ave_data and ave_ch hold until the next ave_valid.
- Latency: ave_valid is asserted exactly 2 cycles after the final accepted conv_done, with WAIT→OUT registered on that conv_done edge.
- After OUT, if another enabled channel exists above the current one, go to SEL.
- After OUT on the last enabled channel, pulse scan_done in the same cycle as that ave_valid. Then:
  - continuous=1: wrap the pointer to channel 0 and go to SEL. The mask is not re-latched.
  - continuous=0: go to IDLE.
- Abort: abort=1 in any state forces IDLE on the next edge. No ave_valid or scan_done is issued for the partial channel. A conv_done arriving afterward is ignored.
- Reset mid-scan: identical to power-up reset.
- Throughput: N+DISCARD requests per channel, no idle cycles beyond the FSM hops.

Test Plan:
- Single channel: NUM_CH=4, LOG2_N=2, DISCARD=1, ch_mask=4'b0100, conv_data 100,101,102,103 after a discarded 999. Expect 5 conv_req, conv_addr=8'h28, ave_data=102 (rounded 101.5), ave_ch=2, ave_valid 2 cycles after the last conv_done, scan_done coincident.
- Multi-channel scan: ch_mask=4'b1011, constant data per channel (ch0=10, ch1=4095, ch3=0). Expect three ave_valid in order ch0,ch1,ch3 with values 10,4095,0, one scan_done, busy falls afterward.
- Truncate and rounding: ROUND=0, samples 1,1,1,2. Expect 1; with ROUND=1 expect 1 (sum 5+2=7>>2).
- Continuous mode: continuous=1, mask=4'b0001, run 3 scans, then drop continuous. Expect 3 scan_done, return to IDLE after the scan in progress completes, start pulses during busy ignored.
- Timeout: withhold conv_done with TIMEOUT_CYC=16. Expect timeout_err=1 at cycle 16 after conv_req, busy=0, no ave_valid; the next start clears timeout_err.
- Abort and reset: assert abort during the 2nd sample of ch1, then issue a late conv_done. Expect IDLE next cycle, no ave_valid or scan_done, late conv_done ignored. Repeat with rst_n low mid-scan and expect all outputs at reset values asynchronously.
